// File: rtl/mult_block_buffer.sv
// Multiplies operand pairs through a MULT_LAT-stage pipeline, writes the products
// sequentially into an external memory block, and drains the block back on request.
module mult_block_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 64,
  parameter int MULT_LAT = 2,
  parameter int RD_LAT   = 1,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_mult,
  input  logic [DATA_W-1:0] mult_input0,
  input  logic [DATA_W-1:0] mult_input1,
  output logic              RDY_mult,
  output logic              EN_writeMem,
  output logic [ADDR_W-1:0] writeMem_addr,
  output logic [DATA_W-1:0] writeMem_val,
  input  logic              EN_blockRead,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  input  logic [DATA_W-1:0] readMem_val,
  output logic              VALID_memVal,
  output logic [DATA_W-1:0] memVal_data,
  output logic [ADDR_W:0]   fill_count,
  output logic              DONE_blockRead
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  ONE_C      = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_FULL, S_DRAIN, S_FLUSH} state_t;

  state_t             state_reg, state_next;
  logic               rdy_reg, rdy_next;
  logic [ADDR_W:0]    acc_reg, acc_next;
  logic [ADDR_W:0]    fill_reg, fill_next;
  logic [ADDR_W:0]    rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   flush_reg, flush_next;
  logic [MULT_LAT-1:0] pipe_vld_reg;
  logic [DATA_W-1:0]  pipe_data_reg [MULT_LAT];
  logic [RD_LAT-1:0]  rd_vld_reg;

  logic               accept;
  logic               in_flight;
  logic               a_ext, b_ext;
  logic [2*DATA_W-1:0] op_a, op_b, prod_full;
  logic [DATA_W-1:0]  prod_red;

  assign accept    = EN_mult && rdy_reg;
  assign in_flight = |pipe_vld_reg;

  // Sign-extending to 2*DATA_W makes one unsigned multiply serve both modes.
  assign a_ext     = (SIGNED != 0) ? mult_input0[DATA_W-1] : 1'b0;
  assign b_ext     = (SIGNED != 0) ? mult_input1[DATA_W-1] : 1'b0;
  assign op_a      = {{DATA_W{a_ext}}, mult_input0};
  assign op_b      = {{DATA_W{b_ext}}, mult_input1};
  assign prod_full = op_a * op_b;

  always_comb begin
    prod_red = prod_full[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (prod_full[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_full[2*DATA_W-1]}})
          prod_red = prod_full[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}};
      end else if (prod_full[2*DATA_W-1:DATA_W] != '0) begin
        prod_red = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_reg <= '0;
      for (int i = 0; i < MULT_LAT; i++) pipe_data_reg[i] <= '0;
    end else begin
      pipe_vld_reg[0]  <= accept;
      pipe_data_reg[0] <= prod_red;
      for (int i = 1; i < MULT_LAT; i++) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
        pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    fill_next   = fill_reg;
    rd_ptr_next = '0;
    flush_next  = '0;
    if (pipe_vld_reg[MULT_LAT-1]) fill_next = fill_reg + ONE_C;
    if (accept) acc_next = acc_reg + ONE_C;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_FILL;
      S_FILL: begin
        if (acc_reg == DEPTH_C && !in_flight)
          state_next = S_FULL;
        else if (EN_blockRead && !in_flight && fill_reg != '0 && !accept)
          state_next = S_DRAIN;
      end
      S_FULL:  if (EN_blockRead) state_next = S_DRAIN;
      S_DRAIN: begin
        rd_ptr_next = rd_ptr_reg + ONE_C;
        if (rd_ptr_reg == fill_reg - ONE_C) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        flush_next = flush_reg + FLUSH_ONE;
        if (flush_reg == FLUSH_LAST) begin
          state_next = S_IDLE;
          acc_next   = '0;
          fill_next  = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Ready is registered from the next-cycle view so it drops with the DEPTH-th accept.
    rdy_next = (state_next == S_IDLE || state_next == S_FILL) && (acc_next < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      rdy_reg    <= 1'b0;
      acc_reg    <= '0;
      fill_reg   <= '0;
      rd_ptr_reg <= '0;
      flush_reg  <= '0;
      rd_vld_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rdy_reg       <= rdy_next;
      acc_reg       <= acc_next;
      fill_reg      <= fill_next;
      rd_ptr_reg    <= rd_ptr_next;
      flush_reg     <= flush_next;
      rd_vld_reg[0] <= (state_reg == S_DRAIN);
      for (int i = 1; i < RD_LAT; i++) rd_vld_reg[i] <= rd_vld_reg[i-1];
    end
  end

  assign RDY_mult       = rdy_reg;
  assign EN_writeMem    = pipe_vld_reg[MULT_LAT-1];
  assign writeMem_addr  = fill_reg[ADDR_W-1:0];
  assign writeMem_val   = pipe_data_reg[MULT_LAT-1];
  assign EN_readMem     = (state_reg == S_DRAIN);
  assign readMem_addr   = EN_readMem ? rd_ptr_reg[ADDR_W-1:0] : '0;
  assign VALID_memVal   = rd_vld_reg[RD_LAT-1];
  assign memVal_data    = VALID_memVal ? readMem_val : '0;
  assign fill_count     = fill_reg;
  assign DONE_blockRead = VALID_memVal && (state_reg == S_FLUSH) && (flush_reg == FLUSH_LAST);

endmodule

// File: tb/tb_mult_block_buffer.sv
// Directed bench: default block, partial drain, async reset, saturation modes and
// a RD_LAT=3 / DEPTH=8 instance with bubbled input.
module tb_mult_block_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic        en0, br0, rdy0, we0, re0, vv0, done0;
  logic [15:0] a0, b0, wv0, rv0, md0;
  logic [5:0]  wa0, ra0;
  logic [6:0]  fc0;
  logic [15:0] mem0 [64];

  mult_block_buffer u0 (
    .clk(clk), .rst(rst), .EN_mult(en0), .mult_input0(a0), .mult_input1(b0),
    .RDY_mult(rdy0), .EN_writeMem(we0), .writeMem_addr(wa0), .writeMem_val(wv0),
    .EN_blockRead(br0), .EN_readMem(re0), .readMem_addr(ra0), .readMem_val(rv0),
    .VALID_memVal(vv0), .memVal_data(md0), .fill_count(fc0), .DONE_blockRead(done0));

  always @(posedge clk) begin
    if (we0) mem0[wa0] <= wv0;
    if (re0) rv0 <= mem0[ra0];
  end

  logic [15:0] w_addr0 [$];
  logic [15:0] w_val0 [$];
  int          w_cyc0 [$];
  logic [15:0] r_addr0 [$];
  int          r_cyc0 [$];
  logic [15:0] v_data0 [$];
  logic        v_done0 [$];
  int          v_cyc0 [$];
  int          acc_cyc0 [$];
  int          done_cnt0 = 0;

  always @(negedge clk) begin
    if (we0) begin w_addr0.push_back(16'(wa0)); w_val0.push_back(wv0); w_cyc0.push_back(cyc); end
    if (re0) begin r_addr0.push_back(16'(ra0)); r_cyc0.push_back(cyc); end
    if (vv0) begin v_data0.push_back(md0); v_done0.push_back(done0); v_cyc0.push_back(cyc); end
    if (en0 && rdy0) acc_cyc0.push_back(cyc);
    if (done0) done_cnt0 <= done_cnt0 + 1;
  end

  // saturating instances share one operand stream
  logic        en1, rdy1, we1, re1, vv1, done1, rdy2, we2, re2, vv2, done2;
  logic [15:0] a1, b1, wv1, md1, wv2, md2;
  logic [1:0]  wa1, ra1, wa2, ra2;
  logic [2:0]  fc1, fc2;
  logic [15:0] w_val1 [$];
  logic [15:0] w_val2 [$];

  mult_block_buffer #(.DEPTH(4), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .EN_mult(en1), .mult_input0(a1), .mult_input1(b1),
    .RDY_mult(rdy1), .EN_writeMem(we1), .writeMem_addr(wa1), .writeMem_val(wv1),
    .EN_blockRead(1'b0), .EN_readMem(re1), .readMem_addr(ra1), .readMem_val(16'h0),
    .VALID_memVal(vv1), .memVal_data(md1), .fill_count(fc1), .DONE_blockRead(done1));

  mult_block_buffer #(.DEPTH(4), .SIGNED(0), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .EN_mult(en1), .mult_input0(a1), .mult_input1(b1),
    .RDY_mult(rdy2), .EN_writeMem(we2), .writeMem_addr(wa2), .writeMem_val(wv2),
    .EN_blockRead(1'b0), .EN_readMem(re2), .readMem_addr(ra2), .readMem_val(16'h0),
    .VALID_memVal(vv2), .memVal_data(md2), .fill_count(fc2), .DONE_blockRead(done2));

  always @(negedge clk) begin
    if (we1) w_val1.push_back(wv1);
    if (we2) w_val2.push_back(wv2);
  end

  // long read latency instance
  logic        en3, br3, rdy3, we3, re3, vv3, done3;
  logic [15:0] a3, b3, wv3, rv3, md3, p1, p2;
  logic [2:0]  wa3, ra3;
  logic [3:0]  fc3;
  logic [15:0] mem3 [8];

  mult_block_buffer #(.DEPTH(8), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .EN_mult(en3), .mult_input0(a3), .mult_input1(b3),
    .RDY_mult(rdy3), .EN_writeMem(we3), .writeMem_addr(wa3), .writeMem_val(wv3),
    .EN_blockRead(br3), .EN_readMem(re3), .readMem_addr(ra3), .readMem_val(rv3),
    .VALID_memVal(vv3), .memVal_data(md3), .fill_count(fc3), .DONE_blockRead(done3));

  always @(posedge clk) begin
    if (we3) mem3[wa3] <= wv3;
    if (re3) p1 <= mem3[ra3];
    p2  <= p1;
    rv3 <= p2;
  end

  logic [15:0] w_addr3 [$];
  logic [15:0] w_val3 [$];
  int          w_cyc3 [$];
  logic [15:0] r_addr3 [$];
  int          r_cyc3 [$];
  logic [15:0] v_data3 [$];
  logic        v_done3 [$];
  int          v_cyc3 [$];
  int          done_cnt3 = 0;

  always @(negedge clk) begin
    if (we3) begin w_addr3.push_back(16'(wa3)); w_val3.push_back(wv3); w_cyc3.push_back(cyc); end
    if (re3) begin r_addr3.push_back(16'(ra3)); r_cyc3.push_back(cyc); end
    if (vv3) begin v_data3.push_back(md3); v_done3.push_back(done3); v_cyc3.push_back(cyc); end
    if (done3) done_cnt3 <= done_cnt3 + 1;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  int bw, br, bv, bd, ba;
  logic [15:0] s_exp [4];
  logic [15:0] u_exp [4];
  logic [15:0] sa [4];
  logic [15:0] sb [4];

  initial begin
    en0 = 0; br0 = 0; a0 = 0; b0 = 0;
    en1 = 0; a1 = 0; b1 = 0;
    en3 = 0; br3 = 0; a3 = 0; b3 = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 48'(rdy0), 48'd0);
    check("rst_wen", 48'(we0), 48'd0);
    check("rst_ren", 48'(re0), 48'd0);
    check("rst_valid", 48'(vv0), 48'd0);
    check("rst_done", 48'(done0), 48'd0);
    check("rst_fill", 48'(fc0), 48'd0);
    check("rst_wval", 48'(wv0), 48'd0);
    check("rst_mdata", 48'(md0), 48'd0);
    rst = 1;
    #1 check("rdy_before_edge", 48'(rdy0), 48'd0);
    @(negedge clk);
    check("rdy_after_release", 48'(rdy0), 48'd1);

    // full 64-entry block with pairs (i, i+1)
    bw = w_addr0.size(); ba = acc_cyc0.size();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1; en0 = 1; a0 = 16'(i); b0 = 16'(i + 1);
    end
    @(posedge clk); #1; a0 = 16'hFFFF; b0 = 16'hFFFF;
    @(negedge clk);
    check("rdy_low_after_64", 48'(rdy0), 48'd0);
    repeat (4) @(posedge clk);
    #1 en0 = 0;
    repeat (4) @(negedge clk);
    check("full_fill", 48'(fc0), 48'd64);
    check("full_writes", 48'(w_addr0.size() - bw), 48'd64);
    check("full_rdy", 48'(rdy0), 48'd0);
    check("full_no_read", 48'(r_addr0.size()), 48'd0);
    if (w_addr0.size() - bw >= 64) begin
      check("first_write_lat", 48'(w_cyc0[bw] - acc_cyc0[ba]), 48'd2);
      for (int i = 0; i < 64; i++)
        check($sformatf("wr0_%0d", i), {16'd0, w_addr0[bw+i], w_val0[bw+i]},
              {16'd0, 16'(i), 16'(i * (i + 1))});
    end

    // drain the full block from a one-cycle request
    br = r_addr0.size(); bv = v_data0.size(); bd = done_cnt0;
    @(posedge clk); #1 br0 = 1;
    @(posedge clk); #1 br0 = 0;
    for (int k = 0; k < 200 && (v_data0.size() - bv) < 64; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_reads", 48'(r_addr0.size() - br), 48'd64);
    check("drain_valids", 48'(v_data0.size() - bv), 48'd64);
    check("drain_done_count", 48'(done_cnt0 - bd), 48'd1);
    check("drain_rdy", 48'(rdy0), 48'd1);
    check("drain_fill", 48'(fc0), 48'd0);
    if (r_addr0.size() - br >= 64 && v_data0.size() - bv >= 64) begin
      check("read_lat", 48'(v_cyc0[bv] - r_cyc0[br]), 48'd1);
      for (int i = 0; i < 64; i++)
        check($sformatf("rd0_%0d", i),
              {15'd0, r_addr0[br+i], v_data0[bv+i], v_done0[bv+i]},
              {15'd0, 16'(i), 16'(i * (i + 1)), 1'(i == 63)});
    end

    // partial block, read request held high throughout
    bw = w_addr0.size(); br = r_addr0.size(); bv = v_data0.size(); bd = done_cnt0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; en0 = 1; br0 = 1; a0 = 16'(i + 3); b0 = 16'(i + 7);
    end
    @(posedge clk); #1 en0 = 0;
    for (int k = 0; k < 100 && (v_data0.size() - bv) < 5; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("part_writes", 48'(w_addr0.size() - bw), 48'd5);
    check("part_reads", 48'(r_addr0.size() - br), 48'd5);
    check("part_valids", 48'(v_data0.size() - bv), 48'd5);
    check("part_done_count", 48'(done_cnt0 - bd), 48'd1);
    check("part_fill", 48'(fc0), 48'd0);
    check("part_idle_ignores_req", 48'(re0), 48'd0);
    if (w_addr0.size() - bw >= 5 && r_addr0.size() - br >= 5 && v_data0.size() - bv >= 5) begin
      check("part_drain_start", 48'(r_cyc0[br] - w_cyc0[bw+4]), 48'd2);
      s_exp = '{16'd21, 16'd32, 16'd45, 16'd60};
      for (int i = 0; i < 5; i++)
        check($sformatf("part_%0d", i),
              {15'd0, r_addr0[br+i], v_data0[bv+i], v_done0[bv+i]},
              {15'd0, 16'(i), (i == 4) ? 16'd77 : s_exp[i], 1'(i == 4)});
    end
    br0 = 0;

    // asynchronous reset with two products in flight
    bw = w_addr0.size();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1; en0 = 1; a0 = 16'(i); b0 = 16'd2;
    end
    @(posedge clk); #1; en0 = 0; rst = 0;
    #1;
    check("arst_wen", 48'(we0), 48'd0);
    check("arst_rdy", 48'(rdy0), 48'd0);
    check("arst_fill", 48'(fc0), 48'd0);
    check("arst_wval", 48'(wv0), 48'd0);
    check("arst_writes_before", 48'(w_addr0.size() - bw), 48'd28);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    repeat (6) @(negedge clk);
    check("arst_no_stale", 48'(w_addr0.size() - bw), 48'd28);
    check("arst_rdy_back", 48'(rdy0), 48'd1);
    @(posedge clk); #1; en0 = 1; a0 = 16'd5; b0 = 16'd6;
    @(posedge clk); #1; en0 = 0;
    repeat (4) @(negedge clk);
    check("arst_new_block_writes", 48'(w_addr0.size() - bw), 48'd29);
    if (w_addr0.size() - bw >= 29)
      check("arst_new_block_first", {16'd0, w_addr0[bw+28], w_val0[bw+28]},
            {16'd0, 16'd0, 16'd30});

    // saturation: signed (u1) and unsigned (u2)
    sa = '{16'h7FFF, 16'h8000, 16'hFFFD, 16'hFFFF};
    sb = '{16'h0002, 16'h0002, 16'h0004, 16'h0002};
    s_exp = '{16'h7FFF, 16'h8000, 16'hFFF4, 16'hFFFE};
    u_exp = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bw = w_val1.size(); bv = w_val2.size();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; en1 = 1; a1 = sa[i]; b1 = sb[i];
    end
    @(posedge clk); #1 en1 = 0;
    repeat (5) @(negedge clk);
    check("sat_s_writes", 48'(w_val1.size() - bw), 48'd4);
    check("sat_u_writes", 48'(w_val2.size() - bv), 48'd4);
    check("sat_s_rdy_full", 48'(rdy1), 48'd0);
    if (w_val1.size() - bw >= 4 && w_val2.size() - bv >= 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sat_s_%0d", i), 48'(w_val1[bw+i]), 48'(s_exp[i]));
        check($sformatf("sat_u_%0d", i), 48'(w_val2[bv+i]), 48'(u_exp[i]));
      end

    // RD_LAT=3, DEPTH=8, one pair every other cycle
    bw = w_addr3.size();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; en3 = 1; a3 = 16'(i + 1); b3 = 16'(i + 2);
      @(posedge clk); #1; en3 = 0;
    end
    repeat (5) @(negedge clk);
    check("l3_fill", 48'(fc3), 48'd8);
    check("l3_writes", 48'(w_addr3.size() - bw), 48'd8);
    check("l3_rdy_full", 48'(rdy3), 48'd0);
    if (w_addr3.size() - bw >= 8) begin
      check("l3_bubble", 48'(w_cyc3[bw+1] - w_cyc3[bw]), 48'd2);
      for (int i = 0; i < 8; i++)
        check($sformatf("l3_wr_%0d", i), {16'd0, w_addr3[bw+i], w_val3[bw+i]},
              {16'd0, 16'(i), 16'((i + 1) * (i + 2))});
    end
    br = r_addr3.size(); bv = v_data3.size(); bd = done_cnt3;
    @(posedge clk); #1 br3 = 1;
    @(posedge clk); #1 br3 = 0;
    for (int k = 0; k < 100 && (v_data3.size() - bv) < 8; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("l3_reads", 48'(r_addr3.size() - br), 48'd8);
    check("l3_valids", 48'(v_data3.size() - bv), 48'd8);
    check("l3_done_count", 48'(done_cnt3 - bd), 48'd1);
    check("l3_rdy_after", 48'(rdy3), 48'd1);
    if (r_addr3.size() - br >= 8 && v_data3.size() - bv >= 8)
      for (int i = 0; i < 8; i++) begin
        check($sformatf("l3_lat_%0d", i), 48'(v_cyc3[bv+i] - r_cyc3[br+i]), 48'd3);
        check($sformatf("l3_rd_%0d", i),
              {15'd0, r_addr3[br+i], v_data3[bv+i], v_done3[bv+i]},
              {15'd0, 16'(i), 16'((i + 1) * (i + 2)), 1'(i == 7)});
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
